ripple_count_monitor: RTL and testbench
=======================================

# ripple_count_monitor

Downstream consumer of the 4-bit asynchronous ripple down-counter. It captures the counter's settling, multi-clock-domain output into the system `clk` domain and filters out ripple glitches. It checks that successive stable values follow the legal down (or up) sequence, and presents each accepted value on a valid/ready stream with wrap and error status.

## Interface
- `WIDTH`, 4: width of the monitored count.
- `STABLE_CYCLES`, 2: consecutive equal synchronized samples required before a value is accepted (≥1).
- `DIR_DOWN`, 1: 1 = expected sequence decrements, 0 = increments.
- `WRAP_W`, 8: width of the wrap counter.

- `clk`  in  1  system clock; reset rst, asynchronous, active-low; clock clk.
- `rst`  in  1  asynchronous active-low reset.
- `count_in`  in  WIDTH  raw ripple-counter output, asynchronous to `clk`.
- `resync`  in  1  drop the reference value; the next accepted value is unchecked.
- `err_clear`  in  1  clears `seq_error` and `overrun`.
- `sample_value`  out  WIDTH  accepted count value.
- `sample_valid`  out  1  `sample_value` is pending.
- `sample_ready`  in  1  consumer accepts `sample_value`.
- `seq_error`  out  1  sticky: an illegal transition was seen.
- `overrun`  out  1  sticky: an accepted value was dropped because the buffer was full.
- `wrap_count`  out  WRAP_W  number of wraps, saturating.

## Operation
- Synchronizer: a 2-flop synchronizer turns `count_in` into `s`.
- Stability filter: `stab_cnt` clears when `s` differs from the previous `s`. Otherwise it increments, saturating at `STABLE_CYCLES`.
- Event: raised on the edge where `stab_cnt` becomes `STABLE_CYCLES`, and only if one of these holds:
  - `s` differs from `last_acc`, or
  - the FSM is in ACQUIRE.
- Reaching saturation again without a new value raises no event.
- FSM states:
  - ACQUIRE (reset state): on an event, load `last_acc`, emit the value unchecked, go to TRACK.
  - TRACK: on an event, compare `s` with expected = `last_acc` − 1 (DIR_DOWN) or + 1, modulo 2^WIDTH.
    - Mismatch: set `seq_error`.
    - In all cases: emit the value, update `last_acc`.
  - `resync` in any state: go to ACQUIRE. An event in the same cycle is treated as an ACQUIRE event.
- Wrap: a legal TRACK transition from 0 to 2^WIDTH−1 (down), or from 2^WIDTH−1 to 0 (up), increments `wrap_count`. It saturates at 2^WRAP_W−1. Illegal transitions never count as wraps.
- Output buffer is one entry:
  - Event while the buffer is empty, or with `sample_ready` high in the same cycle: load the value, `sample_valid`=1.
  - Event while `sample_valid` && !`sample_ready`: keep the old value, set `overrun`. Checking still uses the new value.
  - `sample_ready` with no event: `sample_valid`→0.
- Sticky flags: `err_clear` clears them. If a set condition occurs in the same cycle as `err_clear`, the set wins.

## Timing
- Reset values:
  - sync flops 0, `stab_cnt` 0, `last_acc` 0, state ACQUIRE.
  - `sample_value` 0, `sample_valid` 0, `seq_error` 0, `overrun` 0, `wrap_count` 0.
- Latency: `count_in` stable before edge 0 gives `sample_valid`=1 after edge 2+`STABLE_CYCLES` (edge 4 at default).
  - Edges 1–2: synchronizer.
  - Edges 3..: stability counting.
- Glitches shorter than `STABLE_CYCLES`+1 clk periods at `s` are never accepted.
- Flags and `wrap_count` update on the same edge as the event.
- Asserting `rst` mid-operation immediately returns every register to its reset value. The first value after release is unchecked.
- Handshake: transfer happens on an edge with `sample_valid` && `sample_ready`. `sample_value` is held constant while `sample_valid` && !`sample_ready`.

## Structure
- Package `ripple_mon_pkg` holds:
  - the state enum (`ACQUIRE`, `TRACK`);
  - the default `WIDTH`/`WRAP_W` constants;
  - the `next_expected(value, dir)` function.
- Sub-module `sync_stable_filter` contains the 2-flop synchronizer, `stab_cnt` and the event output. Parameters: `WIDTH`, `STABLE_CYCLES`.
- The top level contains the FSM, checker, wrap counter and output buffer.

## Test plan
- Reset, then drive `count_in` 0 → 15 → 14 → 13, each held 10 clk, `sample_ready`=1. Required: outputs 0, 15, 14, 13; `wrap_count`=1; `seq_error`=0; first valid 4 edges after release.
- Glitch: hold 5, pulse 7 for 2 clk, return to 5. Required: no new event; `sample_valid` stays 0 after the 5 is consumed.
- Skip: TRACK at 9, drive 6. Required: `seq_error`=1 on the event edge, value 6 emitted. Then `err_clear` → 0. Then `err_clear` together with a new error → stays 1.
- Backpressure: `sample_ready`=0, drive 3 → 2 → 1. Required: `sample_value` stays 3, `overrun`=1. Then drive 0 and raise `sample_ready` at its event edge: value 0 loaded and still valid, and the expected-value check passed (1 → 0).
- `resync` on the same cycle as an illegal value 12 after 4. Required: no `seq_error`, 12 emitted, next value 11 is legal.
- `rst` asserted mid-run at value 8: all outputs read 0 immediately. After release, a hold of 8 is accepted unchecked.

Source files
------------

// File: rtl/ripple_mon_pkg.sv
// Shared types, default sizes and the sequence helper for the ripple-counter monitor.
package ripple_mon_pkg;

    localparam int DEF_WIDTH  = 4;
    localparam int DEF_WRAP_W = 8;

    typedef enum logic [0:0] {
        ACQUIRE = 1'b0,
        TRACK   = 1'b1
    } mon_state_t;

    // Next legal count after 'value'. The caller truncates the result to its own
    // width, which gives the modulo-2^WIDTH wrap for free.
    function automatic logic [31:0] next_expected(input logic [31:0] value, input logic dir);
        logic [31:0] result;
        if (dir) begin
            result = value - 32'd1;
        end else begin
            result = value + 32'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_stable_filter.sv
// Brings the asynchronous ripple count into clk, then flags the cycle in which
// the synchronized value has stayed unchanged for STABLE_CYCLES edges.
module sync_stable_filter #(
    parameter int WIDTH         = 4,
    parameter int STABLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] count_in,
    output logic [WIDTH-1:0] stable_value,
    output logic             stable_hit
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] STAB_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] STAB_PRE = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAB_ONE = CNT_W'(1);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;
    logic [1:0]       warm_r;
    logic [CNT_W-1:0] stab_cnt_r;
    logic [1:0]       warm_next_s;
    logic [CNT_W-1:0] stab_next_s;
    logic             hit_s;

    // Stability bookkeeping; counting waits until both synchronizer stages hold
    // real samples so the reset zeros are never mistaken for a settled count.
    always_comb begin
        warm_next_s = warm_r;
        stab_next_s = stab_cnt_r;
        hit_s       = 1'b0;
        if (warm_r != 2'd2) begin
            warm_next_s = warm_r + 2'd1;
        end else if (meta_r != sync_r) begin
            stab_next_s = {CNT_W{1'b0}};
        end else if (stab_cnt_r != STAB_MAX) begin
            stab_next_s = stab_cnt_r + STAB_ONE;
            hit_s       = (stab_cnt_r == STAB_PRE);
        end else begin
            stab_next_s = stab_cnt_r;
        end
    end

    // Two-flop synchronizer and stability counter state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_r     <= {WIDTH{1'b0}};
            sync_r     <= {WIDTH{1'b0}};
            warm_r     <= 2'd0;
            stab_cnt_r <= {CNT_W{1'b0}};
        end else begin
            meta_r     <= count_in;
            sync_r     <= meta_r;
            warm_r     <= warm_next_s;
            stab_cnt_r <= stab_next_s;
        end
    end

    assign stable_value = sync_r;
    assign stable_hit   = hit_s;

endmodule

// File: rtl/ripple_count_monitor.sv
// Sequence checker for a ripple counter: accepts settled values, checks each
// against the expected next count, counts wraps and offers values on a
// one-entry valid/ready buffer with sticky error/overrun status.
module ripple_count_monitor
    import ripple_mon_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int STABLE_CYCLES = 2,
    parameter bit DIR_DOWN      = 1'b1,
    parameter int WRAP_W        = DEF_WRAP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  count_in,
    input  logic              resync,
    input  logic              err_clear,
    output logic [WIDTH-1:0]  sample_value,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              seq_error,
    output logic              overrun,
    output logic [WRAP_W-1:0] wrap_count
);

    localparam logic [WIDTH-1:0]  ZERO_VAL = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]  MAX_VAL  = {WIDTH{1'b1}};
    localparam logic [WRAP_W-1:0] WRAP_MAX = {WRAP_W{1'b1}};
    localparam logic [WRAP_W-1:0] WRAP_ONE = WRAP_W'(1);

    mon_state_t        state_r;
    mon_state_t        state_next_s;
    logic [WIDTH-1:0]  last_acc_r;
    logic [WIDTH-1:0]  value_r;
    logic              valid_r;
    logic              seq_error_r;
    logic              overrun_r;
    logic [WRAP_W-1:0] wrap_r;

    logic [WIDTH-1:0]  last_acc_next_s;
    logic [WIDTH-1:0]  value_next_s;
    logic              valid_next_s;
    logic              seq_error_next_s;
    logic              overrun_next_s;
    logic [WRAP_W-1:0] wrap_next_s;

    logic [WIDTH-1:0]  s_s;
    logic              hit_s;
    logic              event_s;
    logic              acq_evt_s;
    logic              trk_evt_s;
    logic [WIDTH-1:0]  expected_s;
    logic              mismatch_s;
    logic              wrap_edge_s;
    logic              wrap_hit_s;
    logic              drop_s;

    sync_stable_filter #(
        .WIDTH        (WIDTH),
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_filter (
        .clk         (clk),
        .rst         (rst),
        .count_in    (count_in),
        .stable_value(s_s),
        .stable_hit  (hit_s)
    );

    // Event qualification, sequence check and wrap detection for this edge.
    // A settled value equal to the last accepted one is a re-saturation, not a
    // new count, unless we are (re)acquiring.
    always_comb begin
        event_s     = hit_s && ((s_s != last_acc_r) || (state_r == ACQUIRE) || resync);
        acq_evt_s   = event_s && ((state_r == ACQUIRE) || resync);
        trk_evt_s   = event_s && !acq_evt_s;
        expected_s  = WIDTH'(next_expected(32'(last_acc_r), DIR_DOWN));
        mismatch_s  = trk_evt_s && (s_s != expected_s);
        wrap_edge_s = DIR_DOWN ? (last_acc_r == ZERO_VAL) : (last_acc_r == MAX_VAL);
        wrap_hit_s  = trk_evt_s && !mismatch_s && wrap_edge_s;
        drop_s      = event_s && valid_r && !sample_ready;
    end

    // Next FSM state: any event leads to tracking, resync alone drops back.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ACQUIRE: begin
                if (event_s) begin
                    state_next_s = TRACK;
                end else begin
                    state_next_s = ACQUIRE;
                end
            end
            TRACK: begin
                if (event_s) begin
                    state_next_s = TRACK;
                end else if (resync) begin
                    state_next_s = ACQUIRE;
                end else begin
                    state_next_s = TRACK;
                end
            end
            default: state_next_s = ACQUIRE;
        endcase
    end

    // Next values for the reference, output buffer, sticky flags and wrap count.
    // Sticky flags give priority to a new set over a clear in the same cycle.
    always_comb begin
        last_acc_next_s  = last_acc_r;
        value_next_s     = value_r;
        valid_next_s     = valid_r;
        seq_error_next_s = seq_error_r;
        overrun_next_s   = overrun_r;
        wrap_next_s      = wrap_r;

        if (event_s) begin
            last_acc_next_s = s_s;
            if (!valid_r || sample_ready) begin
                value_next_s = s_s;
                valid_next_s = 1'b1;
            end else begin
                value_next_s = value_r;
                valid_next_s = 1'b1;
            end
        end else if (sample_ready) begin
            valid_next_s = 1'b0;
        end else begin
            valid_next_s = valid_r;
        end

        if (mismatch_s) begin
            seq_error_next_s = 1'b1;
        end else if (err_clear) begin
            seq_error_next_s = 1'b0;
        end else begin
            seq_error_next_s = seq_error_r;
        end

        if (drop_s) begin
            overrun_next_s = 1'b1;
        end else if (err_clear) begin
            overrun_next_s = 1'b0;
        end else begin
            overrun_next_s = overrun_r;
        end

        if (wrap_hit_s && (wrap_r != WRAP_MAX)) begin
            wrap_next_s = wrap_r + WRAP_ONE;
        end else begin
            wrap_next_s = wrap_r;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ACQUIRE;
            last_acc_r  <= {WIDTH{1'b0}};
            value_r     <= {WIDTH{1'b0}};
            valid_r     <= 1'b0;
            seq_error_r <= 1'b0;
            overrun_r   <= 1'b0;
            wrap_r      <= {WRAP_W{1'b0}};
        end else begin
            state_r     <= state_next_s;
            last_acc_r  <= last_acc_next_s;
            value_r     <= value_next_s;
            valid_r     <= valid_next_s;
            seq_error_r <= seq_error_next_s;
            overrun_r   <= overrun_next_s;
            wrap_r      <= wrap_next_s;
        end
    end

    assign sample_value = value_r;
    assign sample_valid = valid_r;
    assign seq_error    = seq_error_r;
    assign overrun      = overrun_r;
    assign wrap_count   = wrap_r;

endmodule

// File: tb/tb_ripple_count_monitor.sv
// Self-checking bench for ripple_count_monitor: directed scenarios plus random
// count sequences, compared every cycle against a behavioural reference.
module tb_ripple_count_monitor;

    localparam int W  = 4;
    localparam int S  = 2;
    localparam int WW = 8;
    localparam int MODV = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  count_in;
    logic          resync;
    logic          err_clear;
    logic [W-1:0]  sample_value;
    logic          sample_valid;
    logic          sample_ready;
    logic          seq_error;
    logic          overrun;
    logic [WW-1:0] wrap_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state
    int hist[$];
    int n_smp;
    bit m_trk;
    int m_last;
    int m_val;
    bit m_valid;
    bit m_err;
    bit m_ovr;
    int m_wrap;
    int cur;

    always #5 clk = ~clk;

    ripple_count_monitor #(
        .WIDTH(W), .STABLE_CYCLES(S), .DIR_DOWN(1'b1), .WRAP_W(WW)
    ) dut (
        .clk(clk), .rst(rst), .count_in(count_in), .resync(resync),
        .err_clear(err_clear), .sample_value(sample_value),
        .sample_valid(sample_valid), .sample_ready(sample_ready),
        .seq_error(seq_error), .overrun(overrun), .wrap_count(wrap_count)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        hist.delete();
        n_smp   = 0;
        m_trk   = 1'b0;
        m_last  = 0;
        m_val   = 0;
        m_valid = 1'b0;
        m_err   = 1'b0;
        m_ovr   = 1'b0;
        m_wrap  = 0;
    endfunction

    // Called at each rising edge with the inputs that were present before it.
    // hist holds the raw count_in samples taken at earlier edges; a value is
    // settled at this edge when exactly the last S+1 of those samples agree.
    function automatic void model_step();
        bit hit;
        bit ev;
        bit set_err;
        bit set_ovr;
        int v;
        int len;
        int exp;
        if (!rst) begin
            model_reset();
            return;
        end
        hit     = 1'b0;
        set_err = 1'b0;
        set_ovr = 1'b0;
        v       = 0;
        len     = hist.size();
        if (n_smp >= S + 1) begin
            v   = hist[len-1];
            hit = 1'b1;
            for (int i = 1; i <= S; i++) begin
                if (hist[len-1-i] != v) hit = 1'b0;
            end
            if (n_smp > S + 1) begin
                if (hist[len-2-S] == v) hit = 1'b0;
            end
        end
        ev = hit && (!m_trk || (v != m_last) || resync);
        if (ev) begin
            if (m_trk && !resync) begin
                exp = (m_last + MODV - 1) % MODV;
                if (v != exp) begin
                    set_err = 1'b1;
                end else if (m_last == 0 && v == MODV - 1 && m_wrap < 255) begin
                    m_wrap++;
                end
            end
            if (!m_valid || sample_ready) begin
                m_val   = v;
                m_valid = 1'b1;
            end else begin
                set_ovr = 1'b1;
            end
            m_last = v;
            m_trk  = 1'b1;
        end else begin
            if (resync) m_trk = 1'b0;
            if (sample_ready) m_valid = 1'b0;
        end
        m_err = set_err ? 1'b1 : (err_clear ? 1'b0 : m_err);
        m_ovr = set_ovr ? 1'b1 : (err_clear ? 1'b0 : m_ovr);
        hist.push_back(int'(count_in));
        n_smp++;
        while (hist.size() > 8) void'(hist.pop_front());
    endfunction

    task automatic compare_all();
        check_val("value", sample_value, m_val);
        check_val("valid", sample_valid, m_valid);
        check_val("seq_error", seq_error, m_err);
        check_val("overrun", overrun, m_ovr);
        check_val("wrap_count", wrap_count, m_wrap);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic hold(input int v, input int n);
        count_in = 4'(v);
        repeat (n) cycle();
    endtask

    // New value with resync raised exactly on its acceptance edge.
    task automatic hold_resync(input int v);
        count_in = 4'(v);
        repeat (3) cycle();
        resync = 1'b1;
        cycle();
        resync = 1'b0;
        repeat (6) cycle();
    endtask

    task automatic wait_valid(input string tag, input int exp_edges);
        int n;
        n = 0;
        while (!sample_valid && n < 20) begin
            cycle();
            n++;
        end
        check_val(tag, n, exp_edges);
    endtask

    initial begin
        rst          = 1'b0;
        count_in     = 4'd0;
        resync       = 1'b0;
        err_clear    = 1'b0;
        sample_ready = 1'b1;
        model_reset();
        #1;
        compare_all();
        repeat (3) cycle();
        rst = 1'b1;

        // Basic down sequence through the wrap
        wait_valid("first_latency", 4);
        check_val("first_value", sample_value, 0);
        hold(0, 6);
        hold(15, 10);
        hold(14, 10);
        hold(13, 10);
        check_val("wrap_after_seq", wrap_count, 1);
        check_val("seq_ok", seq_error, 0);

        // Glitch rejection
        hold_resync(5);
        hold(7, 2);
        hold(5, 10);
        check_val("glitch_idle", sample_valid, 0);

        // Skipped value
        hold_resync(9);
        count_in = 4'd6;
        repeat (4) cycle();
        check_val("skip_err", seq_error, 1);
        check_val("skip_value", sample_value, 6);
        repeat (6) cycle();
        err_clear = 1'b1;
        cycle();
        err_clear = 1'b0;
        check_val("err_cleared", seq_error, 0);
        count_in = 4'd2;
        repeat (3) cycle();
        err_clear = 1'b1;
        cycle();
        err_clear = 1'b0;
        check_val("set_beats_clear", seq_error, 1);
        repeat (6) cycle();

        // Backpressure
        hold_resync(4);
        err_clear = 1'b1;
        cycle();
        err_clear = 1'b0;
        sample_ready = 1'b0;
        hold(3, 10);
        hold(2, 10);
        hold(1, 10);
        check_val("bp_hold_value", sample_value, 3);
        check_val("bp_overrun", overrun, 1);
        count_in = 4'd0;
        repeat (3) cycle();
        sample_ready = 1'b1;
        cycle();
        check_val("bp_load_value", sample_value, 0);
        check_val("bp_load_valid", sample_valid, 1);
        check_val("bp_check_ok", seq_error, 0);
        repeat (4) cycle();

        // Resync coinciding with an otherwise illegal value
        err_clear = 1'b1;
        cycle();
        err_clear = 1'b0;
        hold_resync(4);
        count_in = 4'd12;
        repeat (3) cycle();
        resync = 1'b1;
        cycle();
        resync = 1'b0;
        check_val("resync_no_err", seq_error, 0);
        check_val("resync_value", sample_value, 12);
        hold(12, 6);
        hold(11, 10);
        check_val("after_resync_legal", seq_error, 0);

        // Asynchronous reset mid-run
        hold(8, 10);
        rst = 1'b0;
        #1;
        model_reset();
        check_val("rst_value", sample_value, 0);
        check_val("rst_valid", sample_valid, 0);
        check_val("rst_seq_error", seq_error, 0);
        check_val("rst_overrun", overrun, 0);
        check_val("rst_wrap", wrap_count, 0);
        repeat (2) cycle();
        rst = 1'b1;
        wait_valid("rst_latency", 4);
        check_val("rst_first_value", sample_value, 8);
        check_val("rst_first_unchecked", seq_error, 0);
        hold(8, 6);

        // Random count sequences, mostly legal, with short glitches and noise
        cur = 8;
        for (int k = 0; k < 300; k++) begin
            int r;
            int len;
            r   = int'($urandom_range(0, 9));
            len = int'($urandom_range(1, 6));
            if (r < 6) begin
                cur = (cur + MODV - 1) % MODV;
            end else if (r >= 7) begin
                cur = int'($urandom_range(0, 15));
            end
            count_in = 4'(cur);
            for (int j = 0; j < len; j++) begin
                sample_ready = ($urandom_range(0, 3) != 0);
                resync       = ($urandom_range(0, 40) == 0);
                err_clear    = ($urandom_range(0, 30) == 0);
                cycle();
            end
        end
        resync       = 1'b0;
        err_clear    = 1'b0;
        sample_ready = 1'b1;
        repeat (10) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
